nibble_result_reader: RTL and testbench

Read-out side of the nibble-loaded adder datapath. Operands go in 4 bits at a time by pushbutton; this block brings the result out the same way.
- A debounced capture button snapshots {carry_out, sum} into a shadow register.
- A debounced step button walks the snapshot one nibble at a time onto 4 LEDs, with an index output.
- Sits between the adder outputs and the board LEDs.

---
 rtl/nibble_reader_pkg.sv | 16 +
 rtl/nibble_result_reader_pb_debounce.sv | 55 +++++
 rtl/nibble_result_reader.sv | 106 ++++++++++
 tb/tb_nibble_result_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_reader_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble result reader.
package nibble_reader_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Number of nibbles needed to hold {carry, sum} for a given sum width.
  function automatic int num_nib(input int width);
    return (width + NIB_W) / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_result_reader_pb_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, counting debouncer and
// rising-edge pulse generator.
module pb_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic pulse
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sync2 != level);
  assign accept = differ && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pb_raw;
      sync2 <= sync1;
    end
  end

  // A level is only accepted after DEB_CYCLES consecutive disagreeing samples;
  // any agreeing sample restarts the count, so short bounces are swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= accept && sync2;
      if (accept) begin
        level <= sync2;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/nibble_result_reader.sv
// Result read-out: snapshots {cout_in, sum_in} on a capture press and shows it
// a nibble at a time on step presses. Define NIBBLE_READER_AUTOSCROLL_EN for auto-scroll.
module nibble_result_reader
  import nibble_reader_pkg::*;
#(
  parameter  int WIDTH         = 7,
  parameter  int DEB_CYCLES    = 4,
  parameter  int SCROLL_CYCLES = 8,
  localparam int NUM_NIB       = num_nib(WIDTH),
  localparam int IDX_W         = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pb_cap,
  input  logic             pb_step,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             cout_in,
  output logic [3:0]       nib_out,
  output logic [IDX_W-1:0] nib_idx,
  output logic             valid,
  output logic             stale
);

  localparam int SNAP_W = NIB_W * NUM_NIB;
  localparam logic [0:0] ST_EMPTY = EMPTY;
  localparam logic [0:0] ST_SHOW  = SHOW;

  logic                          cap_p;
  logic                          step_p;
  logic                          adv;
  logic [0:0]                    state;
  logic [NUM_NIB-1:0][NIB_W-1:0] snap;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              idx_next;
  logic [SNAP_W-1:0]             live;

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_cap_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .pb_raw (pb_cap),
    .pulse  (cap_p)
  );

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .pb_raw (pb_step),
    .pulse  (step_p)
  );

  assign live     = SNAP_W'({cout_in, sum_in});
  assign idx_next = (idx == IDX_W'(NUM_NIB - 1)) ? '0 : idx + 1'b1;

`ifdef NIBBLE_READER_AUTOSCROLL_EN
  localparam int DW_W = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

  logic [DW_W-1:0] dwell;
  logic            expire;

  assign expire = (state == ST_SHOW) && (dwell == DW_W'(SCROLL_CYCLES - 1));
  assign adv    = step_p || expire;

  // Dwell restarts on any index change so a manual step gets a full dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
    end else if ((state != ST_SHOW) || cap_p || step_p || expire) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end
`else
  assign adv = step_p;
`endif

  // Capture has priority over stepping when both pulses land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      snap  <= '0;
      idx   <= '0;
    end else if (cap_p) begin
      state <= ST_SHOW;
      snap  <= live;
      idx   <= '0;
    end else if ((state == ST_SHOW) && adv) begin
      idx <= idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_out <= '0;
      nib_idx <= '0;
      valid   <= 1'b0;
      stale   <= 1'b0;
    end else begin
      nib_out <= snap[idx];
      nib_idx <= idx;
      valid   <= (state == ST_SHOW);
      stale   <= !cap_p && (state == ST_SHOW) && (live != snap);
    end
  end

endmodule

// File: tb/tb_nibble_result_reader.sv
// Self-checking bench for nibble_result_reader (WIDTH=7, DEB_CYCLES=4).
module tb_nibble_result_reader;

  localparam int WIDTH         = 7;
  localparam int DEB_CYCLES    = 4;
  localparam int SCROLL_CYCLES = 8;
  localparam int NNIB          = (WIDTH + 1 + 3) / 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       pb_cap  = 1'b0;
  logic       pb_step = 1'b0;
  logic [6:0] sum_in  = '0;
  logic       cout_in = 1'b0;
  logic [3:0] nib_out;
  logic [0:0] nib_idx;
  logic       valid;
  logic       stale;

  int checks = 0;
  int errors = 0;

  nibble_result_reader #(
    .WIDTH         (WIDTH),
    .DEB_CYCLES    (DEB_CYCLES),
    .SCROLL_CYCLES (SCROLL_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pb_cap  (pb_cap),
    .pb_step (pb_step),
    .sum_in  (sum_in),
    .cout_in (cout_in),
    .nib_out (nib_out),
    .nib_idx (nib_idx),
    .valid   (valid),
    .stale   (stale)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         cap;
    bit         step;
    logic [6:0] sum;
    logic       cout;
    logic [3:0] nib;
    logic       idx;
    logic       vld;
    logic       stl;
  } vec_t;

  vec_t vecs[8];

  // Reference model: snapshot word, displayed index and capture flag.
  logic [7:0] m_snap;
  int         m_idx;
  bit         m_valid;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic [3:0] n, input logic i,
                          input logic v, input logic s);
    checkOutput({name, ".nib"},   8'(nib_out), 8'(n));
    checkOutput({name, ".idx"},   8'(nib_idx), 8'(i));
    checkOutput({name, ".valid"}, 8'(valid),   8'(v));
    checkOutput({name, ".stale"}, 8'(stale),   8'(s));
  endtask

  task automatic pressButtons(input bit c, input bit s, input int hold);
    pb_cap  = c;
    pb_step = s;
    tick(hold);
    pb_cap  = 1'b0;
    pb_step = 1'b0;
    tick(12);
  endtask

  task automatic applyStimulus(input vec_t v);
    sum_in  = v.sum;
    cout_in = v.cout;
    if (v.cap || v.step) pressButtons(v.cap, v.step, 8);
    else tick(2);
  endtask

  task automatic modelPress(input bit c, input bit s);
    if (c) begin
      m_snap  = {cout_in, sum_in};
      m_idx   = 0;
      m_valid = 1'b1;
    end else if (s && m_valid) begin
      m_idx = (m_idx + 1) % NNIB;
    end
  endtask

  function automatic logic [3:0] modelNib();
    return 4'((m_snap >> (4 * m_idx)) & 8'h0F);
  endfunction

  function automatic logic modelStale();
    return m_valid && ({cout_in, sum_in} != m_snap);
  endfunction

  task automatic runAutoscroll();
    int   changes[$];
    int   step_at;
    int   exp_iv[7];
    logic prev;
    exp_iv  = '{8, 8, 8, 8, 3, 8, 8};
    step_at = -1;
    sum_in  = 7'h5A;
    cout_in = 1'b1;
    pressButtons(1'b1, 1'b0, 8);
    checkOutput("scroll_valid", 8'(valid), 8'd1);
    prev = nib_idx;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      tick(1);
      if (nib_idx !== prev) changes.push_back(cyc);
      prev = nib_idx;
      if ((changes.size() == 4) && (step_at < 0)) step_at = cyc + 3;
      if (cyc == step_at) pb_step = 1'b1;
      if (cyc == step_at + 10) pb_step = 1'b0;
    end
    checkOutput("scroll_count", 8'(changes.size() >= 8), 8'd1);
    for (int k = 0; k < 7; k++) begin
      if (k + 1 < changes.size())
        checkOutput($sformatf("scroll_iv%0d", k), 8'(changes[k+1] - changes[k]), 8'(exp_iv[k]));
    end
  endtask

  initial begin
    int op, hold, len;
    bit c, s;

    vecs[0] = '{1'b0, 1'b1, 7'h5A, 1'b1, 4'hD, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 7'h5A, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 7'h01, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 7'h01, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 7'h01, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 7'h2C, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 7'h2C, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 7'h2C, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    tick(3);
    checkAll("reset", 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(2);
    checkAll("post_reset", 4'h0, 1'b0, 1'b0, 1'b0);

`ifdef NIBBLE_READER_AUTOSCROLL_EN
    runAutoscroll();
`else
    // Stepping before any capture must leave the display blank.
    pb_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) pb_step = 1'b0;
      tick(1);
      checkAll("empty_step", 4'h0, 1'b0, 1'b0, 1'b0);
    end

    // First capture: output must change exactly on the 8th sampling edge.
    sum_in  = 7'h5A;
    cout_in = 1'b1;
    pb_cap  = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      if (e == 7) checkAll("cap_edge7", 4'h0, 1'b0, 1'b0, 1'b0);
      if (e == 8) checkAll("cap_edge8", 4'hA, 1'b0, 1'b1, 1'b0);
    end
    pb_cap = 1'b0;
    tick(12);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].nib, vecs[i].idx, vecs[i].vld, vecs[i].stl);
    end

    // Bounce of 2-cycle levels is rejected; a long hold advances exactly once.
    pb_step = 1'b1; tick(2);
    pb_step = 1'b0; tick(2);
    pb_step = 1'b1; tick(2);
    pb_step = 1'b0; tick(12);
    checkAll("bounce", 4'hC, 1'b0, 1'b1, 1'b0);
    pb_step = 1'b1;
    tick(20);
    checkAll("held", 4'hA, 1'b1, 1'b1, 1'b0);
    pb_step = 1'b0;
    tick(12);
    checkAll("held_release", 4'hA, 1'b1, 1'b1, 1'b0);

    // Stale flag follows the live word one cycle later; recapture clears it.
    sum_in  = 7'h5A;
    cout_in = 1'b1;
    tick(1);
    checkAll("stale_live", 4'hA, 1'b1, 1'b1, 1'b1);
    pressButtons(1'b1, 1'b0, 8);
    checkAll("stale_cap", 4'hA, 1'b0, 1'b1, 1'b0);
    sum_in = 7'h01;
    tick(1);
    checkAll("stale_set", 4'hA, 1'b0, 1'b1, 1'b1);
    pressButtons(1'b1, 1'b0, 8);
    checkAll("stale_clear", 4'h1, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a capture debounce.
    pb_cap = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    checkAll("rst_mid", 4'h0, 1'b0, 1'b0, 1'b0);
    pb_cap = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    checkAll("rst_after", 4'h0, 1'b0, 1'b0, 1'b0);

    m_snap  = '0;
    m_idx   = 0;
    m_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          sum_in  = 7'($urandom);
          cout_in = 1'($urandom);
          tick(2);
        end
        3: begin
          len = $urandom_range(1, DEB_CYCLES - 1);
          if ($urandom_range(0, 1) == 1) pb_cap = 1'b1;
          else pb_step = 1'b1;
          tick(len);
          pb_cap  = 1'b0;
          pb_step = 1'b0;
          tick(12);
        end
        default: begin
          c    = (op == 1) || (op == 4);
          s    = (op == 2) || (op == 4);
          hold = $urandom_range(DEB_CYCLES, 10);
          pressButtons(c, s, hold);
          modelPress(c, s);
        end
      endcase
      checkAll($sformatf("rand%0d", n), modelNib(), 1'(m_idx), m_valid, modelStale());
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
